// File: rtl/vga_fb_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : vga_fb_scheduler
//  Purpose  : Shares one single-port frame-buffer RAM between display
//             prefetch (priority, keeps a pixel FIFO ahead of scan-out) and
//             an external pixel writer that uses the leftover cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module vga_fb_scheduler #(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 12,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              iVGA_CLK,
  input  logic              iRST_n,
  input  logic              iVS,
  input  logic              iBLANK_n,
  output logic [DATA_W-1:0] oPIX,
  output logic              oUNDERFLOW,
  input  logic              iWR_REQ,
  input  logic [ADDR_W-1:0] iWR_ADDR,
  input  logic [DATA_W-1:0] iWR_DATA,
  output logic              oWR_ACK,
  output logic [ADDR_W-1:0] oMEM_ADDR,
  output logic [DATA_W-1:0] oMEM_WDATA,
  output logic              oMEM_WE,
  input  logic [DATA_W-1:0] iMEM_RDATA
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] C_FRAME_PIX = ADDR_W'(H_ACTIVE * V_ACTIVE);
  localparam logic [CNT_W:0]    C_DEPTH     = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_WAIT_VS = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_FETCH   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                vs_q;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  // Read pipeline: stage 1 = address on the bus, stage 2 = data on iMEM_RDATA.
  logic                s1_vld_q, s2_vld_q, s2_drop_q;
  logic [DATA_W-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wptr_q, rptr_q;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [DATA_W-1:0]   pix_q;
  logic                uf_q, ack_q, we_q;
  logic [ADDR_W-1:0]   maddr_q;
  logic [DATA_W-1:0]   mwdata_q;

  logic                frame_start, flush, rd_grant, wr_grant, push, pop, empty;
  logic [CNT_W:0]      reserved;

  assign frame_start = vs_q & ~iVS;
  assign flush       = (state_q == ST_FLUSH);
  assign empty       = (count_q == '0);
  // FIFO slots already holding data plus reads still on their way back.
  assign reserved    = {1'b0, count_q} + (CNT_W + 1)'(s1_vld_q) + (CNT_W + 1)'(s2_vld_q);
  assign rd_grant    = (state_q == ST_FETCH) && (rd_addr_q < C_FRAME_PIX) && (reserved < C_DEPTH);
  assign wr_grant    = !rd_grant && iWR_REQ && !flush;
  assign push        = s2_vld_q && !s2_drop_q && !flush;
  assign pop         = iBLANK_n && !flush && !empty;

  // Next-state, fetch address and FIFO occupancy.
  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    count_d   = count_q;
    if (frame_start) begin
      state_d = ST_FLUSH;
    end else begin
      case (state_q)
        ST_WAIT_VS: state_d = ST_WAIT_VS;
        ST_FLUSH:   state_d = ST_FETCH;
        ST_FETCH:   if (rd_addr_q == C_FRAME_PIX) state_d = ST_DONE;
        ST_DONE:    state_d = ST_DONE;
        default:    state_d = ST_WAIT_VS;
      endcase
    end
    if (flush)         rd_addr_d = '0;
    else if (rd_grant) rd_addr_d = rd_addr_q + 1'b1;
    if (flush)             count_d = '0;
    else if (push && !pop) count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  // State register plus the vsync edge detector.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q <= ST_WAIT_VS;
      vs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      vs_q    <= iVS;
    end
  end

  // FIFO storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge iVGA_CLK) begin
    if (push) fifo_mem[wptr_q] <= iMEM_RDATA;
  end

  // Fetch pointer, read pipeline, FIFO pointers and pixel output.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      rd_addr_q <= '0;
      s1_vld_q  <= 1'b0;
      s2_vld_q  <= 1'b0;
      s2_drop_q <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      pix_q     <= '0;
      uf_q      <= 1'b0;
    end else begin
      rd_addr_q <= rd_addr_d;
      count_q   <= count_d;
      s1_vld_q  <= rd_grant;
      s2_vld_q  <= s1_vld_q;
      // A read launched before the flush returns stale data; drop it.
      s2_drop_q <= flush;
      if (flush) begin
        wptr_q <= '0;
        rptr_q <= '0;
        pix_q  <= '0;
        uf_q   <= 1'b0;
      end else begin
        if (push) wptr_q <= wptr_q + 1'b1;
        if (pop)  rptr_q <= rptr_q + 1'b1;
        if (iBLANK_n && !empty) begin
          pix_q <= fifo_mem[rptr_q];
        end else begin
          pix_q <= '0;
          if (iBLANK_n) uf_q <= 1'b1;
        end
      end
    end
  end

  // Registered RAM bus: prefetch read, else writer, else idle with address held.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      maddr_q  <= '0;
      mwdata_q <= '0;
      we_q     <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      ack_q <= wr_grant;
      if (rd_grant) begin
        maddr_q <= rd_addr_q;
        we_q    <= 1'b0;
      end else if (wr_grant) begin
        maddr_q  <= iWR_ADDR;
        mwdata_q <= iWR_DATA;
        we_q     <= 1'b1;
      end else begin
        we_q <= 1'b0;
      end
    end
  end

  assign oPIX       = pix_q;
  assign oUNDERFLOW = uf_q;
  assign oWR_ACK    = ack_q;
  assign oMEM_ADDR  = maddr_q;
  assign oMEM_WDATA = mwdata_q;
  assign oMEM_WE    = we_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_fb_scheduler
//  Purpose  : Self-checking bench for vga_fb_scheduler on a reduced 16x4 frame
//             with a transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_fb_scheduler;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 12;
  localparam int H_ACT  = 16;
  localparam int V_ACT  = 4;
  localparam int DEPTH  = 16;
  localparam int TOTAL  = H_ACT * V_ACT;

  localparam int P_WAIT = 0, P_FLUSH = 1, P_FETCH = 2, P_DONE = 3;

  logic              clk = 1'b0;
  logic              rst_n, vs, blank_n, wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rdata = '0;
  logic [DATA_W-1:0] pix, mem_wdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              uf, ack, mem_we;

  vga_fb_scheduler #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .H_ACTIVE(H_ACT),
    .V_ACTIVE(V_ACT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .iVGA_CLK(clk), .iRST_n(rst_n), .iVS(vs), .iBLANK_n(blank_n),
    .oPIX(pix), .oUNDERFLOW(uf), .iWR_REQ(wr_req), .iWR_ADDR(wr_addr),
    .iWR_DATA(wr_data), .oWR_ACK(ack), .oMEM_ADDR(mem_addr),
    .oMEM_WDATA(mem_wdata), .oMEM_WE(mem_we), .iMEM_RDATA(rdata)
  );

  always #5 clk = ~clk;

  // Frame pixels are a scrambled function of address so pixel 0 is non-zero
  // and distinguishable from the blank/underflow value.
  function automatic int pixf(input int a);
    return (a * 7 + 3) & 'hFFF;
  endfunction

  // Synchronous RAM: data valid one cycle after the address is presented.
  logic [DATA_W-1:0] ram [1024];
  always @(posedge clk) begin
    rdata <= ram[mem_addr[9:0]];
    if (mem_we) ram[mem_addr[9:0]] <= mem_wdata;
  end

  // ---------------- reference model ----------------
  typedef struct { int addr; int edge_n; bit drop; } pend_t;
  int     m_phase, m_next, edge_n;
  bit     m_vsp;
  int     m_fifo[$];
  pend_t  m_pend[$];
  logic [ADDR_W-1:0] e_addr;
  logic [DATA_W-1:0] e_wdata, e_pix;
  logic              e_we, e_ack, e_uf;

  int n_pass = 0, n_total = 0, wr_mode = 0;

  task automatic model_reset();
    m_phase = P_WAIT; m_next = 0; m_vsp = 1'b0; edge_n = 0;
    m_fifo.delete(); m_pend.delete();
    e_addr = '0; e_wdata = '0; e_pix = '0; e_we = 1'b0; e_ack = 1'b0; e_uf = 1'b0;
  endtask

  task automatic model_edge();
    bit fs, fl, rdg, wrg;
    int resv, nph;
    pend_t p;
    fs   = m_vsp && !vs;
    fl   = (m_phase == P_FLUSH);
    resv = m_fifo.size() + m_pend.size();
    rdg  = (m_phase == P_FETCH) && (m_next < TOTAL) && (resv < DEPTH);
    wrg  = !rdg && wr_req && !fl;
    if (fs)                                        nph = P_FLUSH;
    else if (m_phase == P_FLUSH)                   nph = P_FETCH;
    else if (m_phase == P_FETCH && m_next == TOTAL) nph = P_DONE;
    else                                           nph = m_phase;
    // display side
    if (fl) begin
      e_pix = '0; e_uf = 1'b0;
    end else if (blank_n) begin
      if (m_fifo.size() > 0) e_pix = DATA_W'(m_fifo.pop_front());
      else begin e_pix = '0; e_uf = 1'b1; end
    end else begin
      e_pix = '0;
    end
    // read data lands two edges after the read was launched
    if (m_pend.size() > 0 && m_pend[0].edge_n == edge_n - 2) begin
      p = m_pend.pop_front();
      if (!p.drop && !fl) m_fifo.push_back(pixf(p.addr));
    end
    if (fl) begin
      m_fifo.delete();
      foreach (m_pend[i]) m_pend[i].drop = 1'b1;
      m_next = 0;
    end
    // memory side
    e_ack = wrg;
    if (rdg) begin
      p.addr = m_next; p.edge_n = edge_n; p.drop = 1'b0;
      m_pend.push_back(p);
      e_addr = ADDR_W'(m_next); e_we = 1'b0;
      m_next++;
    end else if (wrg) begin
      e_addr = wr_addr; e_wdata = wr_data; e_we = 1'b1;
    end else begin
      e_we = 1'b0;
    end
    m_phase = nph;
    m_vsp   = vs;
    edge_n++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic check_all();
    chk("mem_we",    32'(mem_we),    32'(e_we));
    chk("mem_addr",  32'(mem_addr),  32'(e_addr));
    chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
    chk("wr_ack",    32'(ack),       32'(e_ack));
    chk("pix",       32'(pix),       32'(e_pix));
    chk("underflow", 32'(uf),        32'(e_uf));
  endtask

  // Writer: holds a request until acked, then picks the next one by mode
  // (0 = stop, 1 = random, 2 = always requesting).
  task automatic writer_update();
    if (!wr_req || e_ack) begin
      wr_addr = ADDR_W'($urandom_range(1023, TOTAL));
      wr_data = DATA_W'($urandom);
      case (wr_mode)
        1:       wr_req = 1'($urandom_range(0, 1));
        2:       wr_req = 1'b1;
        default: wr_req = 1'b0;
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    writer_update();
  endtask

  task automatic vs_pulse();
    vs = 1'b0; tick(); vs = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = DATA_W'(pixf(i));
    rst_n = 1'b0; vs = 1'b1; blank_n = 1'b0; wr_req = 1'b0;
    wr_addr = '0; wr_data = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;

    // Write while waiting for the first frame.
    wr_req = 1'b1; wr_addr = 19'h00100; wr_data = 12'hABC;
    repeat (4) tick();

    // Frame start: prefill of 16 reads, then quiet.
    vs_pulse();
    repeat (24) tick();

    // One active line with the writer permanently requesting.
    wr_mode = 2; wr_req = 1'b1;
    blank_n = 1'b1;
    repeat (H_ACT) tick();
    blank_n = 1'b0;
    repeat (24) tick();
    wr_mode = 0;

    // Pops start two cycles after frame start: underflow, then cleared.
    vs_pulse();
    tick();
    blank_n = 1'b1;
    repeat (30) tick();
    blank_n = 1'b0;
    repeat (3) tick();
    vs_pulse();
    repeat (3) tick();

    // Frame restart at varying depths into the fetch (reads in flight).
    for (int k = 28; k <= 42; k++) begin
      vs_pulse();
      blank_n = 1'b1;
      repeat (k) tick();
      blank_n = 1'b0;
    end
    vs_pulse();
    repeat (20) tick();

    // Whole frame popped, past end of frame, then queued writes in DONE.
    wr_mode = 1;
    vs_pulse();
    for (int i = 0; i < 160; i++) begin
      blank_n = ($urandom_range(0, 3) != 0);
      tick();
    end
    blank_n = 1'b0;
    wr_mode = 2; wr_req = 1'b1;
    repeat (12) tick();

    // Asynchronous reset in the middle of a write stream.
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1 rst_n = 1'b1;
    wr_mode = 0;
    repeat (6) tick();

    // Random soak: random sync, blanking and writes.
    wr_mode = 1;
    for (int i = 0; i < 400; i++) begin
      vs      = ($urandom_range(0, 59) != 0);
      blank_n = ($urandom_range(0, 2) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
